// File: rtl/uart_pkg.sv
// UART shared definitions: parity modes, receiver FSM encoding
// and the baud divider helper used by both RX and TX.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_HIGH
    } rx_state_t;

    function automatic int baud_div(
        input int clk_hz,
        input int baud,
        input int os
    );
        return clk_hz / (baud * os) - 1;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO for received frames.
// A push into a full FIFO is accepted only when a pop frees a slot.
module uart_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             not_empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign not_empty = (count != '0);
    assign full      = (count == FULL_CNT);
    assign do_pop    = pop && not_empty;
    assign do_push   = push && (!full || do_pop);
    assign head      = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (AW+1)'(1);
            end else if (do_pop && !do_push) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-FF synchroniser, oversampling
// majority-vote sampler, framing FSM and FWFT output FIFO.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQUENCY_HZ = 50_000_000,
    parameter int BAUD_RATE        = 781_250,
    parameter int OVERSAMPLE       = 16,
    parameter int DATA_BITS        = 8,
    parameter int PARITY           = 0,
    parameter int STOP_BITS        = 1,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_frame_err,
    output logic                 m_parity_err,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 overrun,
    output logic                 busy
);
    localparam int DIV = baud_div(CLK_FREQUENCY_HZ, BAUD_RATE, OVERSAMPLE);
    localparam int DW  = (DIV > 0) ? $clog2(DIV + 1) : 1;
    localparam int OW  = $clog2(OVERSAMPLE);
    localparam int H   = OVERSAMPLE / 2;
    localparam int IW  = $clog2(DATA_BITS);
    localparam int FW  = DATA_BITS + 2;

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV);
    localparam logic [OW-1:0] OS_LAST  = OW'(OVERSAMPLE - 1);
    localparam logic [OW-1:0] OS_A     = OW'(H - 1);
    localparam logic [OW-1:0] OS_B     = OW'(H);
    localparam logic [OW-1:0] OS_DEC   = OW'(H + 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    rx_state_t state;
    rx_state_t state_nx;

    logic                 rx_meta;
    logic                 rx_s;
    logic                 prev_s;
    logic [DW-1:0]        div_cnt;
    logic [OW-1:0]        os_cnt;
    logic                 s_a;
    logic                 s_b;
    logic [IW-1:0]        idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] data;
    logic                 ferr;
    logic                 perr;
    logic                 tick;
    logic                 decide;
    logic                 wrap;
    logic                 maj;
    logic                 start_det;
    logic                 last_stop;
    logic                 stop_ferr;
    logic                 push;
    logic                 fifo_full;
    logic [FW-1:0]        head;

    assign tick      = (div_cnt == DIV_LAST);
    assign decide    = tick && (os_cnt == OS_DEC);
    assign wrap      = tick && (os_cnt == OS_LAST);
    assign maj       = (s_a & s_b) | (s_a & rx_s) | (s_b & rx_s);
    assign start_det = tick && (state == ST_IDLE) && !rx_s && prev_s;
    assign last_stop = (STOP_BITS == 1) || stop_idx;
    assign stop_ferr = ferr | ~maj;
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        push     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start_det) state_nx = ST_START;
            end
            ST_START: begin
                if (decide && maj) state_nx = ST_IDLE;
                else if (wrap)     state_nx = ST_DATA;
            end
            ST_DATA: begin
                if (wrap && idx == IDX_LAST) begin
                    state_nx = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (wrap) state_nx = ST_STOP;
            end
            ST_STOP: begin
                // leave mid-bit so a back-to-back start edge is not missed
                if (decide && last_stop) begin
                    push     = 1'b1;
                    state_nx = stop_ferr ? ST_WAIT_HIGH : ST_IDLE;
                end
            end
            ST_WAIT_HIGH: begin
                if (tick && rx_s) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta  <= 1'b1;
            rx_s     <= 1'b1;
            prev_s   <= 1'b1;
            div_cnt  <= '0;
            os_cnt   <= '0;
            s_a      <= 1'b0;
            s_b      <= 1'b0;
            idx      <= '0;
            stop_idx <= 1'b0;
            data     <= '0;
            ferr     <= 1'b0;
            perr     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            rx_meta <= rxd;
            rx_s    <= rx_meta;
            div_cnt <= tick ? '0 : div_cnt + DW'(1);
            if (tick) begin
                prev_s <= rx_s;
                os_cnt <= (start_det || os_cnt == OS_LAST) ? '0 : os_cnt + OW'(1);
                if (os_cnt == OS_A) s_a <= rx_s;
                if (os_cnt == OS_B) s_b <= rx_s;
            end
            if (start_det) begin
                idx      <= '0;
                stop_idx <= 1'b0;
                ferr     <= 1'b0;
                perr     <= 1'b0;
            end
            if (decide && state == ST_DATA) data[idx] <= maj;
            if (decide && state == ST_PARITY) begin
                perr <= ^data ^ maj ^ (PARITY == PAR_ODD);
            end
            if (decide && state == ST_STOP) begin
                ferr     <= stop_ferr;
                stop_idx <= 1'b1;
            end
            if (wrap && state == ST_DATA) idx <= idx + IW'(1);
            overrun <= push && fifo_full && !(m_valid && m_ready);
        end
    end

    uart_rx_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({stop_ferr, perr, data}),
        .pop       (m_ready),
        .head      (head),
        .not_empty (m_valid),
        .full      (fifo_full)
    );

    assign m_data       = head[DATA_BITS-1:0];
    assign m_parity_err = head[DATA_BITS];
    assign m_frame_err  = head[DATA_BITS+1];

endmodule
